// File: rtl/wta_threshold_unit_pkg.sv
// Shared types and width helper for the winner-take-all threshold stage.
package wta_threshold_unit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      UPDATE = 2'd2
   } state_e;

   // Potential/threshold width produced by a neuron_5in-style neuron.
   function automatic int calc_dw(input int width, input int shift);
      return width + shift + 3;
   endfunction

endpackage

// File: rtl/wta_threshold_unit_threshold_adapt.sv
// One neuron's adaptive threshold; updates only in the cycle i_upd_en is high.
// Winner moves toward its potential by 1/2^p_eta_shift, no winner decays all with saturation at 0.
module wta_threshold_unit_threshold_adapt
   import wta_threshold_unit_pkg::*;
#(
   parameter int DW          = calc_dw(8, 8),
   parameter int p_eta_shift = 4,
   parameter int p_decay     = 1,
   parameter int p_th_init   = 100
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_upd_en,
   input  logic          i_has_winner,
   input  logic          i_is_winner,
   input  logic [DW-1:0] i_win_val,
   output logic [DW-1:0] o_th
);

   logic [DW-1:0] th_q, th_d;
   logic [DW-1:0] diff;

   always_comb begin
      th_d = th_q;
      diff = i_win_val - th_q;
      if (i_upd_en) begin
         if (i_has_winner) begin
            // A winner at or below its own threshold is inconsistent input: leave it alone.
            if (i_is_winner && (i_win_val > th_q)) begin
               th_d = th_q + (diff >> p_eta_shift);
            end
         end else if (th_q > DW'(p_decay)) begin
            th_d = th_q - DW'(p_decay);
         end else begin
            th_d = '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         th_q <= DW'(p_th_init);
      end else begin
         th_q <= th_d;
      end
   end

   assign o_th = th_q;

endmodule

// File: rtl/wta_threshold_unit.sv
// Serial winner-take-all over P_N neuron outputs with optional threshold adaptation; o_valid P_N+1 cycles after accept.
// No backpressure: i_valid is dropped whenever the unit is not IDLE (o_busy high or UPDATE cycle).
module wta_threshold_unit
   import wta_threshold_unit_pkg::*;
#(
   parameter int P_N         = 4,
   parameter int p_width     = 8,
   parameter int p_shift     = 8,
   parameter int p_eta_shift = 4,
   parameter int p_decay     = 1,
   parameter int p_th_init   = 100
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic                                          i_valid,
   input  logic [P_N*calc_dw(p_width, p_shift)-1:0]      i_neuronout,
   input  logic                                          i_learn,
   output logic [P_N*calc_dw(p_width, p_shift)-1:0]      o_threshold,
   output logic [P_N-1:0]                                o_spike,
   output logic [$clog2(P_N+1)-1:0]                      o_winner,
   output logic                                          o_valid,
   output logic                                          o_busy
);

   localparam int DW = calc_dw(p_width, p_shift);
   localparam int IW = $clog2(P_N + 1);

   state_e         state_q, state_d;
   logic [DW-1:0]  data_q [P_N];
   logic [DW-1:0]  data_d [P_N];
   logic           learn_q, learn_d;
   logic [DW-1:0]  best_val_q, best_val_d;
   logic [IW-1:0]  best_idx_q, best_idx_d;
   logic [IW-1:0]  scan_idx_q, scan_idx_d;
   logic [P_N-1:0] spike_q, spike_d;
   logic [IW-1:0]  winner_q, winner_d;
   logic [DW-1:0]  cur_val;
   logic           upd_en;
   logic           has_winner;

   always_comb begin
      cur_val = '0;
      for (int i = 0; i < P_N; i++) begin
         if (scan_idx_q == IW'(i + 1)) cur_val = data_q[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      learn_d    = learn_q;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      scan_idx_d = scan_idx_q;
      spike_d    = spike_q;
      winner_d   = winner_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               for (int i = 0; i < P_N; i++) data_d[i] = i_neuronout[i*DW +: DW];
               learn_d    = i_learn;
               best_val_d = '0;
               best_idx_d = '0;
               scan_idx_d = IW'(1);
               state_d    = SCAN;
            end
         end
         SCAN: begin
            // best starts at 0, so strict '>' also rejects zero outputs and keeps the lowest index on ties.
            if (cur_val > best_val_q) begin
               best_val_d = cur_val;
               best_idx_d = scan_idx_q;
            end
            if (scan_idx_q == IW'(P_N)) begin
               winner_d = best_idx_d;
               for (int i = 0; i < P_N; i++) spike_d[i] = (best_idx_d == IW'(i + 1));
               state_d  = UPDATE;
            end else begin
               scan_idx_d = scan_idx_q + 1'b1;
            end
         end
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         for (int i = 0; i < P_N; i++) data_q[i] <= '0;
         learn_q    <= 1'b0;
         best_val_q <= '0;
         best_idx_q <= '0;
         scan_idx_q <= '0;
         spike_q    <= '0;
         winner_q   <= '0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         learn_q    <= learn_d;
         best_val_q <= best_val_d;
         best_idx_q <= best_idx_d;
         scan_idx_q <= scan_idx_d;
         spike_q    <= spike_d;
         winner_q   <= winner_d;
      end
   end

   assign upd_en     = (state_q == UPDATE) && learn_q;
   assign has_winner = (best_idx_q != '0);

   for (genvar g = 0; g < P_N; g++) begin : g_th
      wta_threshold_unit_threshold_adapt #(
         .DW          (DW),
         .p_eta_shift (p_eta_shift),
         .p_decay     (p_decay),
         .p_th_init   (p_th_init)
      ) u_threshold_adapt (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .i_upd_en     (upd_en),
         .i_has_winner (has_winner),
         .i_is_winner  (best_idx_q == IW'(g + 1)),
         .i_win_val    (best_val_q),
         .o_th         (o_threshold[g*DW +: DW])
      );
   end

   assign o_spike  = spike_q;
   assign o_winner = winner_q;
   assign o_valid  = (state_q == UPDATE);
   assign o_busy   = (state_q != IDLE);

endmodule

// File: doc/wta_threshold_unit.md
Name: wta_threshold_unit

Overview:
- Layer-level stage directly downstream of a group of P_N neuron_5in-style neurons.
- Samples their thresholded outputs on a strobe, serially selects a single winner (winner-take-all) and emits a one-hot spike.
- Optionally adapts the per-neuron thresholds (ODESA style) and drives them back to the neurons' threshold inputs.

Parameters:
- P_N, 4, number of neurons in the layer (>=2).
- p_width, 8, synaptic weight width; must match the neurons.
- p_shift, 8, synapse shift; must match the neurons.
- p_eta_shift, 4, learning-rate right shift for the winner's threshold update.
- p_decay, 1, threshold decrement applied when no neuron fires.
- p_th_init, 100, reset value of every threshold.
- DW (local), p_width+p_shift+3, potential/threshold width (19 at defaults).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  one-cycle strobe: neuron outputs have settled and must be evaluated.
- i_neuronout  in  P_N*DW  neuron outputs; neuron i (1..P_N) occupies [i*DW-1:(i-1)*DW]; 0 means "did not exceed threshold".
- i_learn  in  1  enables threshold adaptation for this evaluation; sampled with i_valid.
- o_threshold  out  P_N*DW  per-neuron thresholds, same packing as i_neuronout; registered.
- o_spike  out  P_N  one-hot winner pulse; bit i-1 corresponds to neuron i; all-zero if no winner.
- o_winner  out  $clog2(P_N+1)  winner index 1..P_N; 0 if no winner.
- o_valid  out  1  one-cycle pulse; o_spike and o_winner are valid in that cycle.
- o_busy  out  1  high from acceptance of i_valid until the o_valid cycle, inclusive.

Behaviour:
- Reset (async, active-high):
  - All thresholds = p_th_init.
  - o_spike=0, o_winner=0, o_valid=0, o_busy=0.
  - FSM goes to IDLE.
  - Asserting reset mid-scan aborts the evaluation: no o_valid and no threshold change.
- FSM states: IDLE, SCAN, UPDATE.
- IDLE:
  - On i_valid, capture i_neuronout and i_learn into internal registers.
  - Clear the best value/index, set the scan index to 1, go to SCAN.
- SCAN:
  - One neuron per cycle, P_N cycles.
  - If the captured value is nonzero and strictly greater than the current best, take it as the new best value and best index.
  - Strict ">" means ties resolve to the lowest index.
  - After index P_N, go to UPDATE.
- UPDATE (one cycle):
  - Drive o_spike, o_winner and o_valid=1.
  - Apply the threshold update if the captured learn bit is set.
  - Return to IDLE.
- Latency: o_valid is asserted exactly P_N+1 cycles after the cycle in which i_valid is sampled in IDLE.
- o_busy timing: high from the cycle after acceptance through the UPDATE cycle.
- i_valid while o_busy=1 is ignored entirely: no queueing and no capture.
- i_valid in the UPDATE cycle is also ignored.
- i_valid in the first IDLE cycle after UPDATE is accepted.
- o_spike and o_winner hold their values until the next UPDATE. o_valid is a single pulse.
- Threshold update (only when learn is set):
  - Winner w exists (best value v > 0): th_w <= th_w + ((v - th_w) >> p_eta_shift), unsigned. If v <= th_w (inconsistent input), th_w is unchanged. The result never exceeds v, so no overflow. Non-winner thresholds are unchanged.
  - No winner: every threshold decrements by p_decay, saturating at 0.
- Thresholds never change outside UPDATE.
- Captured inputs are used for the whole scan, so i_neuronout may change during SCAN.

Decomposition:
- Shared package: DW computation function and the FSM state enum (IDLE/SCAN/UPDATE).
- Sub-module threshold_adapt: one per neuron, generated P_N times. It holds one threshold register and applies the winner/decay rule when its update enable is high.

Test Plan:
- Reset -> all o_threshold = 100; o_spike=0, o_winner=0, o_valid=0, o_busy=0.
- i_valid, i_learn=1, neuron outputs {0,300,0,200} (neurons 1..4) -> o_valid 5 cycles later, o_spike=4'b0010, o_winner=2, th2 = 100+(200>>4) = 112, others 100.
- Tie {250,0,250,0}, i_learn=0 -> o_winner=1, o_spike=4'b0001, all thresholds unchanged.
- All-zero outputs, i_learn=1 -> o_valid with o_spike=0, o_winner=0, all thresholds 99. Force a threshold to 0 and repeat -> that threshold stays 0.
- Second i_valid 2 cycles after the first -> ignored, exactly one o_valid. i_valid on the first cycle after o_valid -> accepted.
- Assert i_rst during SCAN (cycle 2) -> o_busy=0 immediately, no o_valid, thresholds = 100.
